// File: rtl/pipe_stage_buffer.sv
// Elastic FIFO stage latch between processor pipeline stages.
// Carries an opaque payload with a valid/ready handshake on both sides.
// A synchronous flush squashes everything in flight. A sticky overrun
// flag records any push attempt made while the buffer was full.
// Every output depends only on registered state and storage, so no
// combinational path crosses from one side of the buffer to the other.
module pipe_stage_buffer #(
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         DEPTH     = 2,
  parameter logic [DATA_W-1:0]   NOP_VALUE = 16'hF000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             overrun
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a one-bit pointer so the vectors stay legal.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic              overrun_q;

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  head_next;
  logic [PTR_W-1:0]  tail_next;

  // Pointers wrap by explicit compare, because DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] result;
    if (ptr == LAST_PTR) begin
      result = '0;
    end else begin
      result = ptr + PTR_W'(1);
    end
    return result;
  endfunction

  // The handshake is decided from registered occupancy only.
  // A full buffer therefore refuses a push even when a pop happens in the same cycle.
  always_comb begin
    in_ready  = (count_q < FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    head_next = advance(head);
    tail_next = advance(tail);
  end

  // The head entry is presented directly; an empty buffer shows the NOP word instead.
  always_comb begin
    out_data = NOP_VALUE;
    if (count_q != '0) begin
      out_data = mem[head];
    end
  end

  assign count   = count_q;
  assign overrun = overrun_q;

  // Payload storage is not reset; a squashed push is never written.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[tail] <= in_data;
    end
  end

  // Pointers and occupancy update here. Flush outranks any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail <= tail_next;
      end
      if (pop) begin
        head <= head_next;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Overrun is sticky across flushes and clears only on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer.
// A DEPTH=2 and a DEPTH=3 instance share the same stimulus.
// Each instance is compared every cycle against a shift-queue reference model.
// Directed table rows and corner sequences add hand-derived expectations for the DEPTH=2 instance.
module tb_pipe_stage_buffer;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_d  [2];
  logic        out_valid_d [2];
  logic [15:0] out_data_d  [2];
  logic [1:0]  count_d     [2];
  logic        overrun_d   [2];

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the DEPTH=2 instance, index 1 is the DEPTH=3 instance.
  logic [15:0] mq [2][8];
  int          msize [2];
  bit          movr  [2];
  int          mdepth [2];

  logic [15:0] popped3 [$];

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ec;
    logic        er;
    logic        eo;
  } vec_t;

  vec_t vecs [$];

  pipe_stage_buffer #(.DATA_W(16), .DEPTH(2), .NOP_VALUE(16'hF000)) dut2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_d[0]), .in_data(in_data),
    .out_valid(out_valid_d[0]), .out_ready(out_ready), .out_data(out_data_d[0]),
    .count(count_d[0]), .overrun(overrun_d[0])
  );

  pipe_stage_buffer #(.DATA_W(16), .DEPTH(3), .NOP_VALUE(16'hF000)) dut3 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_d[1]), .in_data(in_data),
    .out_valid(out_valid_d[1]), .out_ready(out_ready), .out_data(out_data_d[1]),
    .count(count_d[1]), .overrun(overrun_d[1])
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic ordy,
                              input logic fl, input logic ev, input logic [15:0] ed,
                              input logic [1:0] ec, input logic er, input logic eo);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ec = ec; v.er = er; v.eo = eo;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      msize[k] = 0;
      movr[k]  = 1'b0;
    end
  endtask

  // Advances the model by one clock edge, using the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit can_push;
      can_push = msize[k] < mdepth[k];
      if (in_valid && !can_push) movr[k] = 1'b1;
      if (flush) begin
        msize[k] = 0;
      end else begin
        if (msize[k] > 0 && out_ready) begin
          for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
          msize[k]--;
        end
        if (in_valid && can_push) begin
          mq[k][msize[k]] = in_data;
          msize[k]++;
        end
      end
    end
  endtask

  // Compares both instances against the model.
  task automatic model_compare();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] exp_data;
      exp_data = (msize[k] != 0) ? mq[k][0] : 16'hF000;
      check($sformatf("d%0d_out_valid", mdepth[k]), 32'(out_valid_d[k]), 32'(msize[k] != 0));
      check($sformatf("d%0d_out_data", mdepth[k]), 32'(out_data_d[k]), 32'(exp_data));
      check($sformatf("d%0d_count", mdepth[k]), 32'(count_d[k]), 32'(msize[k]));
      check($sformatf("d%0d_in_ready", mdepth[k]), 32'(in_ready_d[k]), 32'(msize[k] < mdepth[k]));
      check($sformatf("d%0d_overrun", mdepth[k]), 32'(overrun_d[k]), 32'(movr[k]));
    end
  endtask

  // Drives the inputs for one cycle, then compares outputs at the falling edge.
  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clock);
    model_compare();
    if (out_valid_d[1] && out_ready) popped3.push_back(out_data_d[1]);
  endtask

  // Completes the cycle: rising edge, model update, then move off the edge.
  task automatic finish_cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    mdepth[0] = 2;
    mdepth[1] = 3;
    model_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Expectations below are for the DEPTH=2 instance.
    // Columns: iv, data, out_ready, flush | out_valid, out_data, count, in_ready, overrun.
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'hF000, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'hF000, 0, 1, 0));
    vecs.push_back(mk(1, 16'h1234, 1, 0, 0, 16'hF000, 0, 1, 0));
    vecs.push_back(mk(1, 16'h5678, 1, 0, 1, 16'h1234, 1, 1, 0));
    vecs.push_back(mk(1, 16'h9ABC, 1, 0, 1, 16'h5678, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h9ABC, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'hF000, 0, 1, 0));
    vecs.push_back(mk(1, 16'hA001, 0, 0, 0, 16'hF000, 0, 1, 0));
    vecs.push_back(mk(1, 16'hA002, 0, 0, 1, 16'hA001, 1, 1, 0));
    vecs.push_back(mk(1, 16'hA003, 0, 0, 1, 16'hA001, 2, 0, 0));
    vecs.push_back(mk(1, 16'hA003, 1, 0, 1, 16'hA001, 2, 0, 1));
    vecs.push_back(mk(1, 16'hA003, 1, 0, 1, 16'hA002, 1, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA003, 1, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'hF000, 0, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid_d[0]), 32'(vecs[i].ev));
      check($sformatf("vec%0d_out_data", i), 32'(out_data_d[0]), 32'(vecs[i].ed));
      check($sformatf("vec%0d_count", i), 32'(count_d[0]), 32'(vecs[i].ec));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready_d[0]), 32'(vecs[i].er));
      check($sformatf("vec%0d_overrun", i), 32'(overrun_d[0]), 32'(vecs[i].eo));
      finish_cycle();
    end

    // Flush priority: two entries held, then flush together with a push and a pop.
    drive(1, 16'h00B1, 0, 0); finish_cycle();
    drive(1, 16'h00B2, 0, 0); finish_cycle();
    drive(1, 16'h00B3, 1, 1);
    check("flush_pre_count", 32'(count_d[0]), 32'd2);
    finish_cycle();
    drive(0, 16'h0000, 0, 0);
    check("flush_count", 32'(count_d[0]), 32'd0);
    check("flush_out_valid", 32'(out_valid_d[0]), 32'd0);
    check("flush_out_data", 32'(out_data_d[0]), 32'hF000);
    check("flush_overrun_kept", 32'(overrun_d[0]), 32'd1);
    finish_cycle();
    drive(0, 16'h0000, 1, 0);
    check("flush_b3_absent", 32'(count_d[0]), 32'd0);
    finish_cycle();

    // Wrap on the DEPTH=3 instance: seven streamed values must come out in order.
    drive(0, 16'h0000, 0, 1); finish_cycle();
    popped3.delete();
    for (int i = 1; i <= 7; i++) begin
      drive(1, 16'(i), 1, 0);
      finish_cycle();
    end
    drive(0, 16'h0000, 1, 0); finish_cycle();
    drive(0, 16'h0000, 1, 0); finish_cycle();
    check("wrap_pop_count", 32'(popped3.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      logic [15:0] got;
      got = (i < popped3.size()) ? popped3[i] : 16'hFFFF;
      check($sformatf("wrap_order%0d", i), 32'(got), 32'(i + 1));
    end

    // Asynchronous reset dropped between clock edges with two entries held.
    drive(1, 16'h00C1, 0, 0); finish_cycle();
    drive(1, 16'h00C2, 0, 0); finish_cycle();
    check("areset_pre_count", 32'(count_d[0]), 32'd2);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("areset_count", 32'(count_d[0]), 32'd0);
    check("areset_out_valid", 32'(out_valid_d[0]), 32'd0);
    check("areset_out_data", 32'(out_data_d[0]), 32'hF000);
    check("areset_d3_count", 32'(count_d[1]), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    drive(1, 16'h0042, 1, 0);
    check("after_reset_empty", 32'(out_valid_d[0]), 32'd0);
    finish_cycle();
    drive(0, 16'h0000, 1, 0);
    check("after_reset_valid", 32'(out_valid_d[0]), 32'd1);
    check("after_reset_data", 32'(out_data_d[0]), 32'h0042);
    finish_cycle();

    // Randomized traffic against the model, with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)),
            ($urandom_range(15) == 0));
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
